// File: rtl/srm_controller.sv
// Multicycle Moore sequencer for the Simple RISC Machine datapath.
// Steps one latched instruction through read, execute and writeback.
module srm_controller #(
    parameter logic [2:0] OPC_ALU = 3'b101,
    parameter logic [2:0] OPC_MOV = 3'b110
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       write,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_WAIT     = 3'd0,
        S_DECODE   = 3'd1,
        S_WR_IMM   = 3'd2,
        S_GET_A    = 3'd3,
        S_GET_B    = 3'd4,
        S_EXEC     = 3'd5,
        S_EXEC_CMP = 3'd6,
        S_WR_REG   = 3'd7
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] opcode_q, opcode_d;
    logic [1:0] op_q, op_d;

    logic is_mov_imm, is_mov_reg, is_mvn, is_alu2, is_cmp, is_legal;

    // Instruction class is decoded from the latched fields only
    always_comb begin
        is_mov_imm = (opcode_q == OPC_MOV) && (op_q == 2'b10);
        is_mov_reg = (opcode_q == OPC_MOV) && (op_q == 2'b00);
        is_mvn     = (opcode_q == OPC_ALU) && (op_q == 2'b11);
        is_alu2    = (opcode_q == OPC_ALU) && (op_q != 2'b11);
        is_cmp     = (opcode_q == OPC_ALU) && (op_q == 2'b01);
        is_legal   = is_mov_imm | is_mov_reg | is_mvn | is_alu2;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_WAIT;
            opcode_q <= 3'b000;
            op_q     <= 2'b00;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            op_q     <= op_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        op_d     = op_q;
        unique case (state_q)
            S_WAIT: begin
                if (s) begin
                    state_d  = S_DECODE;
                    opcode_d = opcode;
                    op_d     = op;
                end
            end
            S_DECODE: begin
                if (is_mov_imm) begin
                    state_d = S_WR_IMM;
                end else if (is_mov_reg || is_mvn) begin
                    state_d = S_GET_B;
                end else if (is_alu2) begin
                    state_d = S_GET_A;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WR_IMM:   state_d = S_WAIT;
            S_GET_A:    state_d = S_GET_B;
            S_GET_B:    state_d = is_cmp ? S_EXEC_CMP : S_EXEC;
            S_EXEC:     state_d = S_WR_REG;
            S_EXEC_CMP: state_d = S_WAIT;
            S_WR_REG:   state_d = S_WAIT;
            default:    state_d = S_WAIT;
        endcase
    end

    always_comb begin
        w       = 1'b0;
        nsel    = 3'b000;
        vsel    = 2'b00;
        loada   = 1'b0;
        loadb   = 1'b0;
        loadc   = 1'b0;
        loads   = 1'b0;
        asel    = 1'b0;
        bsel    = 1'b0;
        write   = 1'b0;
        illegal = 1'b0;
        unique case (state_q)
            S_WAIT:   w = 1'b1;
            S_DECODE: illegal = !is_legal;
            S_WR_IMM: begin
                nsel  = 3'b100;
                vsel  = 2'b01;
                write = 1'b1;
            end
            S_GET_A: begin
                nsel  = 3'b100;
                loada = 1'b1;
            end
            S_GET_B: begin
                nsel  = 3'b001;
                loadb = 1'b1;
            end
            S_EXEC: begin
                loadc = 1'b1;
                asel  = is_mov_reg;
            end
            S_EXEC_CMP: loads = 1'b1;
            S_WR_REG: begin
                nsel  = 3'b010;
                write = 1'b1;
            end
            default: w = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_srm_controller.sv
// Bench for srm_controller: per-cycle output traces against a step-list model.
// Directed table, hand sequences for reset/abort/back-to-back, random run.
module tb_srm_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       loada, loadb, loadc, loads, asel, bsel, write, illegal;

    int checks = 0;
    int failures = 0;

    srm_controller dut (
        .clk(clk), .reset_n(reset_n), .s(s), .opcode(opcode), .op(op),
        .w(w), .nsel(nsel), .vsel(vsel), .loada(loada), .loadb(loadb),
        .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
        .write(write), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Output word: {w,nsel,vsel,loada,loadb,loadc,loads,asel,bsel,write,illegal}
    function automatic logic [13:0] mk(
        input logic w_e, input logic [2:0] ns, input logic [1:0] vs,
        input logic la, input logic lb, input logic lc, input logic ls,
        input logic as, input logic wr, input logic il);
        return {w_e, ns, vs, la, lb, lc, ls, as, 1'b0, wr, il};
    endfunction

    function automatic logic [13:0] act();
        return {w, nsel, vsel, loada, loadb, loadc, loads,
                asel, bsel, write, illegal};
    endfunction

    localparam logic [13:0] IDLE = 14'b1_000_00_0000_0_0_0_0;

    logic [13:0] exp_q[$];

    // Reference: list of expected non-wait cycles for one instruction
    function automatic void model(input logic [2:0] opc, input logic [1:0] f);
        bit mov_imm, mov_reg, mvn, cmp, two_src;
        mov_imm = (opc == 3'b110) && (f == 2'b10);
        mov_reg = (opc == 3'b110) && (f == 2'b00);
        mvn     = (opc == 3'b101) && (f == 2'b11);
        cmp     = (opc == 3'b101) && (f == 2'b01);
        two_src = (opc == 3'b101) && (f != 2'b11);
        exp_q.delete();
        if (!(mov_imm || mov_reg || mvn || two_src)) begin
            exp_q.push_back(mk(0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 1));
            return;
        end
        exp_q.push_back(mk(0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        if (mov_imm) begin
            exp_q.push_back(mk(0, 3'b100, 2'b01, 0, 0, 0, 0, 0, 1, 0));
            return;
        end
        if (two_src)
            exp_q.push_back(mk(0, 3'b100, 2'b00, 1, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(0, 3'b001, 2'b00, 0, 1, 0, 0, 0, 0, 0));
        if (cmp) begin
            exp_q.push_back(mk(0, 3'b000, 2'b00, 0, 0, 0, 1, 0, 0, 0));
        end else begin
            exp_q.push_back(mk(0, 3'b000, 2'b00, 0, 0, 1, 0, mov_reg, 0, 0));
            exp_q.push_back(mk(0, 3'b010, 2'b00, 0, 0, 0, 0, 0, 1, 0));
        end
    endfunction

    task automatic check(input string name, input logic [13:0] got,
                         input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input string name, input logic [2:0] opc,
                             input logic [1:0] f, input bit hold,
                             output int busy);
        s = 1'b1;
        opcode = opc;
        op = f;
        tick();
        if (!hold) s = 1'b0;
        opcode = 3'($urandom_range(0, 7));
        op = 2'($urandom_range(0, 3));
        model(opc, f);
        busy = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (w == 1'b0) busy++;
            check($sformatf("%s.c%0d", name, i), act(), exp_q[i]);
            tick();
        end
        check({name, ".wait"}, act(), IDLE);
    endtask

    typedef struct {
        logic [2:0] opc;
        logic [1:0] f;
        int         busy;
        string      name;
    } vec_t;

    vec_t tbl[10];
    int busy;

    initial begin
        tbl[0] = '{3'b110, 2'b10, 2, "mov_imm"};
        tbl[1] = '{3'b110, 2'b00, 4, "mov_reg"};
        tbl[2] = '{3'b101, 2'b11, 4, "mvn"};
        tbl[3] = '{3'b101, 2'b00, 5, "add"};
        tbl[4] = '{3'b101, 2'b10, 5, "and"};
        tbl[5] = '{3'b101, 2'b01, 4, "cmp"};
        tbl[6] = '{3'b111, 2'b00, 1, "ill_111"};
        tbl[7] = '{3'b110, 2'b01, 1, "ill_110_01"};
        tbl[8] = '{3'b000, 2'b00, 1, "ill_000"};
        tbl[9] = '{3'b110, 2'b11, 1, "ill_110_11"};

        // Reset held with a pending start must keep WAIT outputs
        reset_n = 1'b0;
        s = 1'b1;
        opcode = 3'b110;
        op = 2'b10;
        #1;
        check("reset.async", act(), IDLE);
        tick();
        tick();
        check("reset.held", act(), IDLE);
        reset_n = 1'b1;
        run_instr("post_reset", 3'b110, 2'b10, 1'b0, busy);
        check_int("post_reset.busy", busy, 2);

        foreach (tbl[i]) begin
            run_instr(tbl[i].name, tbl[i].opc, tbl[i].f, 1'b0, busy);
            check_int({tbl[i].name, ".busy"}, busy, tbl[i].busy);
            tick();
            check({tbl[i].name, ".idle"}, act(), IDLE);
        end

        // s held high: exactly one WAIT cycle between instructions
        run_instr("b2b0", 3'b110, 2'b10, 1'b1, busy);
        run_instr("b2b1", 3'b110, 2'b10, 1'b1, busy);
        run_instr("b2b2", 3'b101, 2'b11, 1'b0, busy);
        check_int("b2b2.busy", busy, 4);

        // Abort ADD in GET_B
        s = 1'b1;
        opcode = 3'b101;
        op = 2'b00;
        tick();
        s = 1'b0;
        tick();
        tick();
        check("abort.get_b", act(),
              mk(0, 3'b001, 2'b00, 0, 1, 0, 0, 0, 0, 0));
        reset_n = 1'b0;
        #1;
        check("abort.async", act(), IDLE);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("abort.hold%0d", i), act(), IDLE);
        end
        reset_n = 1'b1;
        tick();
        check("abort.release", act(), IDLE);

        // Random instruction mix with idle gaps
        for (int n = 0; n < 150; n++) begin
            logic [2:0] ro;
            logic [1:0] rf;
            int gap;
            case ($urandom_range(0, 3))
                0: ro = 3'b101;
                1: ro = 3'b110;
                2: ro = 3'b101;
                default: ro = 3'($urandom_range(0, 7));
            endcase
            rf = 2'($urandom_range(0, 3));
            run_instr($sformatf("rnd%0d", n), ro, rf, 1'b0, busy);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                opcode = 3'($urandom_range(0, 7));
                op = 2'($urandom_range(0, 3));
                tick();
                check($sformatf("rnd%0d.gap%0d", n, g), act(), IDLE);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
